exe_stage: RTL and testbench
============================

Name: exe_stage

Overview:
- Execute stage of the 5-stage in-order MIPS pipeline (IF, ID, EXE, MEM, WB). Sits directly downstream of the decode stage.
- Latches the decoded bundle from ID and computes the ALU result.
- Issues the data-SRAM request for lw/sw and passes the result bundle to MEM.
- Returns a forwarding/hazard bus to ID. ID stalls only when a lw in EXE conflicts with one of its source registers.

Parameters:
- none; bus widths come from the mycpu.h macros: DS_TO_ES_BUS_WD=136, ES_TO_MS_BUS_WD=71, ES_TO_DS_BUS_WD=38.

Ports:
- clk  in  1  clock; one clock domain.
- reset  in  1  synchronous, active-high reset.
- ms_allowin  in  1  MEM stage can accept an instruction this cycle.
- es_allowin  out  1  EXE stage can accept an instruction this cycle.
- ds_to_es_valid  in  1  ID is presenting a valid instruction.
- ds_to_es_bus  in  136  decoded bundle, in order from MSB: alu_op[135:124], load_op[123], src1_is_sa[122], src1_is_pc[121], src2_is_imm[120], src2_is_8[119], gr_we[118], mem_we[117], dest[116:112], imm[111:96], rs_value[95:64], rt_value[63:32], pc[31:0].
- es_to_ms_valid  out  1  EXE is presenting a valid instruction to MEM.
- es_to_ms_bus  out  71  {res_from_mem[70], gr_we[69], dest[68:64], alu_result[63:32], pc[31:0]}.
- es_to_ds_bus  out  38  {es_res_valid[37], es_dest[36:32], es_res[31:0]}.
- data_sram_en  out  1  data SRAM enable.
- data_sram_wen  out  4  data SRAM byte write enables.
- data_sram_addr  out  32  data SRAM address.
- data_sram_wdata  out  32  data SRAM write data.

Behaviour:
- Reset:
  - es_valid=0 and the latched bundle es_bus_r=0.
  - All outputs are therefore 0, except es_allowin=1 and es_res_valid=1.
- Handshake:
  - es_ready_go=1 (single-cycle execute).
  - es_allowin = !es_valid || (es_ready_go && ms_allowin).
  - es_to_ms_valid = es_valid && es_ready_go.
- Sequential update:
  - On each posedge, if reset, clear both registers.
  - Otherwise, if es_allowin: es_valid <= ds_to_es_valid.
  - If ds_to_es_valid && es_allowin: es_bus_r <= ds_to_es_bus. Otherwise es_bus_r holds.
  - A MEM stall (ms_allowin=0) with es_valid=1 freezes es_valid, es_bus_r and every derived output.
- Operand select:
  - src1 = src1_is_sa ? {27'b0, imm[10:6]} : src1_is_pc ? pc : rs_value.
  - src2 = src2_is_imm ? sign-extended imm : src2_is_8 ? 32'd8 : rt_value.
- alu_op is one-hot:
  - [0] add: src1 + src2, modulo 2^32, no overflow trap.
  - [1] sub: src1 − src2.
  - [2] slt: signed compare, result 0/1.
  - [3] sltu: unsigned compare, result 0/1.
  - [4] and; [5] nor; [6] or; [7] xor.
  - [8] sll: src2 << src1[4:0].
  - [9] srl: logical shift right.
  - [10] sra: arithmetic shift right.
  - [11] lui: {src2[15:0], 16'b0}.
  - alu_result is the OR of each op result ANDed with its op bit. An all-zero alu_op gives 0. Multiple bits set OR their results; this is defined but never generated by ID.
- Memory request (issued only in the handoff cycle, so exactly one request per instruction even under MEM stall):
  - data_sram_en = es_valid && ms_allowin && (load_op || mem_we).
  - data_sram_wen = {4{es_valid && ms_allowin && mem_we}}.
  - data_sram_addr = alu_result.
  - data_sram_wdata = rt_value.
- To MEM: res_from_mem = load_op; gr_we, dest and pc pass through unchanged.
- To ID:
  - es_dest = dest when (es_valid && gr_we), else 5'd0.
  - es_res = alu_result.
  - es_res_valid = !(es_valid && load_op). It is 0 only while a lw occupies EXE, including while that lw is stalled by MEM.

Test Plan:
- Reset with reset=1 for 2 cycles, then release → es_allowin=1, es_to_ms_valid=0, data_sram_en=0, es_to_ds_bus=38'h20_0000_0000.
- addu with rs_value=32'h7FFF_FFFF, rt_value=1, dest=8, ms_allowin=1 → next cycle es_to_ms_valid=1, alu_result=32'h8000_0000; es_to_ds_bus = {1, 5'd8, 32'h8000_0000}.
- sra with imm[10:6]=4, rt_value=32'hF000_0000 → alu_result=32'hFF00_0000; repeat as srl → 32'h0F00_0000.
- lw with rs_value=32'h1000, imm=16'hFFFC, dest=2:
  - data_sram_en=1, wen=0, addr=32'h0FFC.
  - es_res_valid=0, es_dest=2.
  - res_from_mem=1 on es_to_ms_bus.
- sw with rt_value=32'hDEAD_BEEF while ms_allowin=0 for 3 cycles, then 1:
  - Stall cycles: es_allowin=0, data_sram_wen=0, outputs held.
  - Release cycle: wen=4'hF, wdata=32'hDEAD_BEEF for exactly one cycle.
- Valid lw in EXE with reset asserted mid-stall → next cycle es_valid=0, es_res_valid=1, data_sram_en=0. A new instruction is accepted the cycle after reset deasserts.

Source files
------------

// File: rtl/exe_stage.sv
// Execute stage of the 5-stage in-order MIPS pipeline: latches the ID bundle,
// runs the one-hot ALU, issues the data-SRAM request and feeds MEM and ID.
module exe_stage (
    input  logic         clk,
    input  logic         reset,
    input  logic         ms_allowin,
    output logic         es_allowin,
    input  logic         ds_to_es_valid,
    input  logic [135:0] ds_to_es_bus,
    output logic         es_to_ms_valid,
    output logic [70:0]  es_to_ms_bus,
    output logic [37:0]  es_to_ds_bus,
    output logic         data_sram_en,
    output logic [3:0]   data_sram_wen,
    output logic [31:0]  data_sram_addr,
    output logic [31:0]  data_sram_wdata
);

    // Each op result is gated by its one-hot bit and OR-ed, so an empty
    // alu_op yields zero and overlapping bits combine rather than prioritise.
    function automatic logic [31:0] alu(input logic [11:0] op,
                                        input logic [31:0] a,
                                        input logic [31:0] b);
        logic [31:0] res;
        res = '0;
        res |= {32{op[0]}}  & (a + b);
        res |= {32{op[1]}}  & (a - b);
        res |= {32{op[2]}}  & {31'd0, ($signed(a) < $signed(b))};
        res |= {32{op[3]}}  & {31'd0, (a < b)};
        res |= {32{op[4]}}  & (a & b);
        res |= {32{op[5]}}  & ~(a | b);
        res |= {32{op[6]}}  & (a | b);
        res |= {32{op[7]}}  & (a ^ b);
        res |= {32{op[8]}}  & (b << a[4:0]);
        res |= {32{op[9]}}  & (b >> a[4:0]);
        res |= {32{op[10]}} & 32'($signed(b) >>> a[4:0]);
        res |= {32{op[11]}} & {b[15:0], 16'd0};
        return res;
    endfunction

    logic         r_es_valid;
    logic [135:0] r_es_bus;

    logic         w_es_ready_go;
    logic [11:0]  w_alu_op;
    logic         w_load_op;
    logic         w_src1_is_sa;
    logic         w_src1_is_pc;
    logic         w_src2_is_imm;
    logic         w_src2_is_8;
    logic         w_gr_we;
    logic         w_mem_we;
    logic [4:0]   w_dest;
    logic [15:0]  w_imm;
    logic [31:0]  w_rs_value;
    logic [31:0]  w_rt_value;
    logic [31:0]  w_pc;
    logic [31:0]  w_src1;
    logic [31:0]  w_src2;
    logic [31:0]  w_alu_result;
    logic         w_handoff;

    assign {w_alu_op, w_load_op, w_src1_is_sa, w_src1_is_pc, w_src2_is_imm,
            w_src2_is_8, w_gr_we, w_mem_we, w_dest, w_imm, w_rs_value,
            w_rt_value, w_pc} = r_es_bus;

    assign w_es_ready_go  = 1'b1;
    assign es_allowin     = !r_es_valid || (w_es_ready_go && ms_allowin);
    assign es_to_ms_valid = r_es_valid && w_es_ready_go;

    always_ff @(posedge clk) begin
        if (reset) begin
            r_es_valid <= 1'b0;
            r_es_bus   <= '0;
        end else begin
            if (es_allowin) begin
                r_es_valid <= ds_to_es_valid;
            end
            if (ds_to_es_valid && es_allowin) begin
                r_es_bus <= ds_to_es_bus;
            end
        end
    end

    assign w_src1 = w_src1_is_sa ? {27'd0, w_imm[10:6]} :
                    w_src1_is_pc ? w_pc : w_rs_value;
    assign w_src2 = w_src2_is_imm ? {{16{w_imm[15]}}, w_imm} :
                    w_src2_is_8   ? 32'd8 : w_rt_value;

    assign w_alu_result = alu(w_alu_op, w_src1, w_src2);

    // Request only in the cycle MEM takes the instruction, so a stall never repeats it.
    assign w_handoff       = r_es_valid && ms_allowin;
    assign data_sram_en    = w_handoff && (w_load_op || w_mem_we);
    assign data_sram_wen   = {4{w_handoff && w_mem_we}};
    assign data_sram_addr  = w_alu_result;
    assign data_sram_wdata = w_rt_value;

    assign es_to_ms_bus = {w_load_op, w_gr_we, w_dest, w_alu_result, w_pc};

    assign es_to_ds_bus = {!(r_es_valid && w_load_op),
                           (r_es_valid && w_gr_we) ? w_dest : 5'd0,
                           w_alu_result};

endmodule

// File: tb/tb_exe_stage.sv
// Directed-vector bench for exe_stage: hand-computed expectations checked with
// immediate assertions one step at a time.
module tb_exe_stage;

    logic         clk;
    logic         reset;
    logic         ms_allowin;
    logic         es_allowin;
    logic         ds_to_es_valid;
    logic [135:0] ds_to_es_bus;
    logic         es_to_ms_valid;
    logic [70:0]  es_to_ms_bus;
    logic [37:0]  es_to_ds_bus;
    logic         data_sram_en;
    logic [3:0]   data_sram_wen;
    logic [31:0]  data_sram_addr;
    logic [31:0]  data_sram_wdata;

    int n_vec = 0;
    int n_bad = 0;

    exe_stage dut (
        .clk            (clk),
        .reset          (reset),
        .ms_allowin     (ms_allowin),
        .es_allowin     (es_allowin),
        .ds_to_es_valid (ds_to_es_valid),
        .ds_to_es_bus   (ds_to_es_bus),
        .es_to_ms_valid (es_to_ms_valid),
        .es_to_ms_bus   (es_to_ms_bus),
        .es_to_ds_bus   (es_to_ds_bus),
        .data_sram_en   (data_sram_en),
        .data_sram_wen  (data_sram_wen),
        .data_sram_addr (data_sram_addr),
        .data_sram_wdata(data_sram_wdata)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic logic [135:0] mk(input logic [11:0] op, input logic ld,
                                        input logic sa, input logic ipc,
                                        input logic simm, input logic s8,
                                        input logic gwe, input logic mwe,
                                        input logic [4:0] d, input logic [15:0] imm,
                                        input logic [31:0] rs, input logic [31:0] rt,
                                        input logic [31:0] pc);
        return {op, ld, sa, ipc, simm, s8, gwe, mwe, d, imm, rs, rt, pc};
    endfunction

    task automatic chk(input string tag, input logic [70:0] obs, input logic [70:0] exp);
        n_vec++;
        assert (obs === exp) else begin
            n_bad++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    // Advance one clock and settle just after the edge.
    task automatic step();
        @(posedge clk);
        #1;
    endtask

    initial begin
        reset          = 1'b1;
        ms_allowin     = 1'b1;
        ds_to_es_valid = 1'b0;
        ds_to_es_bus   = '0;
        step();
        step();
        reset = 1'b0;
        #1;
        chk("rst_allowin", 71'(es_allowin), 71'd1);
        chk("rst_ms_valid", 71'(es_to_ms_valid), 71'd0);
        chk("rst_sram_en", 71'(data_sram_en), 71'd0);
        chk("rst_to_ds", 71'(es_to_ds_bus), 71'(38'h20_0000_0000));
        chk("rst_to_ms", es_to_ms_bus, 71'd0);

        // addu wrapping past the signed maximum
        ds_to_es_valid = 1'b1;
        ds_to_es_bus = mk(12'h001, 0, 0, 0, 0, 0, 1, 0, 5'd8, 16'h0000,
                          32'h7FFF_FFFF, 32'h0000_0001, 32'hBFC0_0000);
        step();
        chk("addu_ms_valid", 71'(es_to_ms_valid), 71'd1);
        chk("addu_result", 71'(es_to_ms_bus[63:32]), 71'(32'h8000_0000));
        chk("addu_to_ds", 71'(es_to_ds_bus), 71'({1'b1, 5'd8, 32'h8000_0000}));
        chk("addu_to_ms", es_to_ms_bus, {1'b0, 1'b1, 5'd8, 32'h8000_0000, 32'hBFC0_0000});
        chk("addu_sram_en", 71'(data_sram_en), 71'd0);

        // sra / srl by imm[10:6]=4
        ds_to_es_bus = mk(12'h400, 0, 1, 0, 0, 0, 1, 0, 5'd3, 16'h0100,
                          32'h0, 32'hF000_0000, 32'hBFC0_0004);
        step();
        chk("sra_result", 71'(es_to_ms_bus[63:32]), 71'(32'hFF00_0000));
        ds_to_es_bus = mk(12'h200, 0, 1, 0, 0, 0, 1, 0, 5'd3, 16'h0100,
                          32'h0, 32'hF000_0000, 32'hBFC0_0008);
        step();
        chk("srl_result", 71'(es_to_ms_bus[63:32]), 71'(32'h0F00_0000));

        // slt vs sltu with -1 and 1
        ds_to_es_bus = mk(12'h004, 0, 0, 0, 0, 0, 1, 0, 5'd4, 16'h0,
                          32'hFFFF_FFFF, 32'h1, 32'hBFC0_000C);
        step();
        chk("slt_result", 71'(es_to_ms_bus[63:32]), 71'd1);
        ds_to_es_bus = mk(12'h008, 0, 0, 0, 0, 0, 1, 0, 5'd4, 16'h0,
                          32'hFFFF_FFFF, 32'h1, 32'hBFC0_0010);
        step();
        chk("sltu_result", 71'(es_to_ms_bus[63:32]), 71'd0);

        // lui with gr_we=0 hides dest from ID
        ds_to_es_bus = mk(12'h800, 0, 0, 0, 1, 0, 0, 0, 5'd9, 16'h1234,
                          32'h0, 32'h0, 32'hBFC0_0014);
        step();
        chk("lui_to_ds", 71'(es_to_ds_bus), 71'({1'b1, 5'd0, 32'h1234_0000}));

        // jal-style link: pc + 8
        ds_to_es_bus = mk(12'h001, 0, 0, 1, 0, 1, 1, 0, 5'd31, 16'h0,
                          32'h0, 32'h0, 32'hBFC0_0018);
        step();
        chk("link_result", 71'(es_to_ms_bus[63:32]), 71'(32'hBFC0_0020));

        // lw with negative offset
        ds_to_es_bus = mk(12'h001, 1, 0, 0, 1, 0, 1, 0, 5'd2, 16'hFFFC,
                          32'h0000_1000, 32'h0, 32'hBFC0_001C);
        step();
        chk("lw_sram_en", 71'(data_sram_en), 71'd1);
        chk("lw_sram_wen", 71'(data_sram_wen), 71'd0);
        chk("lw_sram_addr", 71'(data_sram_addr), 71'(32'h0000_0FFC));
        chk("lw_to_ds", 71'(es_to_ds_bus), 71'({1'b0, 5'd2, 32'h0000_0FFC}));
        chk("lw_res_from_mem", 71'(es_to_ms_bus[70]), 71'd1);

        // sw held by a 3-cycle MEM stall
        ds_to_es_bus = mk(12'h001, 0, 0, 0, 1, 0, 0, 1, 5'd0, 16'h0010,
                          32'h0000_2000, 32'hDEAD_BEEF, 32'hBFC0_0020);
        step();
        ms_allowin = 1'b0;
        ds_to_es_bus = mk(12'h001, 0, 0, 0, 0, 0, 1, 0, 5'd7, 16'h0,
                          32'h5, 32'h6, 32'hBFC0_0024);
        #1;
        for (int c = 0; c < 3; c++) begin
            chk("sw_stall_allowin", 71'(es_allowin), 71'd0);
            chk("sw_stall_wen", 71'(data_sram_wen), 71'd0);
            chk("sw_stall_hold", es_to_ms_bus, {1'b0, 1'b0, 5'd0, 32'h0000_2010, 32'hBFC0_0020});
            if (c < 2) step();
        end
        ms_allowin = 1'b1;
        #1;
        chk("sw_release_wen", 71'(data_sram_wen), 71'hF);
        chk("sw_release_en", 71'(data_sram_en), 71'd1);
        chk("sw_release_wdata", 71'(data_sram_wdata), 71'(32'hDEAD_BEEF));
        chk("sw_release_addr", 71'(data_sram_addr), 71'(32'h0000_2010));
        ds_to_es_valid = 1'b0;
        step();
        chk("sw_after_wen", 71'(data_sram_wen), 71'd0);
        chk("sw_after_valid", 71'(es_to_ms_valid), 71'd0);

        // lw stalled in EXE, then reset mid-stall
        ds_to_es_valid = 1'b1;
        ds_to_es_bus = mk(12'h001, 1, 0, 0, 1, 0, 1, 0, 5'd5, 16'h0004,
                          32'h0000_3000, 32'h0, 32'hBFC0_0028);
        step();
        ds_to_es_valid = 1'b0;
        ms_allowin = 1'b0;
        #1;
        chk("lw_stall_res_valid", 71'(es_to_ds_bus[37]), 71'd0);
        chk("lw_stall_sram_en", 71'(data_sram_en), 71'd0);
        reset = 1'b1;
        step();
        chk("midrst_ms_valid", 71'(es_to_ms_valid), 71'd0);
        chk("midrst_res_valid", 71'(es_to_ds_bus[37]), 71'd1);
        chk("midrst_sram_en", 71'(data_sram_en), 71'd0);
        chk("midrst_allowin", 71'(es_allowin), 71'd1);
        reset = 1'b0;
        ms_allowin = 1'b1;
        ds_to_es_valid = 1'b1;
        ds_to_es_bus = mk(12'h001, 0, 0, 0, 0, 0, 1, 0, 5'd6, 16'h0,
                          32'h0000_0010, 32'h0000_0020, 32'hBFC0_002C);
        step();
        chk("postrst_ms_valid", 71'(es_to_ms_valid), 71'd1);
        chk("postrst_to_ds", 71'(es_to_ds_bus), 71'({1'b1, 5'd6, 32'h0000_0030}));

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end

endmodule
